// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : {pc, instr} pair at the default 32/32 widths
//   NOP_INSTR     : canonical RISC-V nop (addi x0, x0, 0)
//   if_cnt_w()    : occupancy counter width for a given queue depth
package if_pkg;

  localparam int unsigned IF_PC_W       = 32;
  localparam int unsigned IF_INSTR_W    = 32;
  localparam int unsigned IF_FIFO_DEPTH = 2;
  localparam int unsigned IF_CNT_W      = $clog2(IF_FIFO_DEPTH) + 1;

  localparam logic [IF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IF_PC_W-1:0]    pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Counter must hold 0..depth inclusive, hence one extra bit over the pointer.
  function automatic int unsigned if_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO, generic over element type.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears storage too)
//   push_i / data_i     write request and data
//   pop_i               read request; data_o is the registered head
//   flush_i             empties the queue; wins over push and pop
//   full_o / empty_o    occupancy flags
//   count_o             number of stored entries (0..DEPTH)
// A pop in the same cycle frees the slot, so push into a full FIFO with a
// concurrent pop is legal.
module if_sync_fifo
  import if_pkg::*;
#(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = if_cnt_w(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Pointer and count next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full_o && !do_pop));

  assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage between the PC register and decode.
// Issues the current PC to instruction memory (req/gnt), tags each accepted
// request with its PC, buffers returned instructions in order, and presents
// them to decode over valid/ready. A jump flushes buffered data and marks
// every still-outstanding request as stale so its response is discarded.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   pc, jump                      current fetch PC; redirect (loads PC reg)
//   pc_stall_n                    1 = PC register advances this cycle
//   imem_req/addr/gnt             request handshake to instruction memory
//   imem_rvalid/rdata             in-order response, never back-pressured
//   id_valid/ready/instr/pc       decode-side handshake and payload
// Optional build macro: IF_FETCH_BYPASS_EN enables a zero-latency path from
// imem_rdata to decode when nothing is buffered.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH,
  parameter int unsigned PC_W       = IF_PC_W,
  parameter int unsigned INSTR_W    = IF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc,
  input  logic               jump,
  output logic               pc_stall_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
);

  localparam int unsigned CNT_W = if_cnt_w(FIFO_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic             accept;
  logic             credit_ok;
  logic [SUM_W-1:0] occupancy;

  logic [PC_W-1:0]  tag_head;
  logic             tag_full, tag_empty;
  logic [CNT_W-1:0] tag_cnt;

  entry_t           ibuf_din, ibuf_head;
  logic             ibuf_push, ibuf_pop;
  logic             ibuf_full, ibuf_empty;
  logic [CNT_W-1:0] ibuf_cnt;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             resp_keep;

  // Outstanding requests plus buffered entries may never exceed the buffer size,
  // so every kept response is guaranteed a slot.
  assign occupancy = SUM_W'(tag_cnt) + SUM_W'(ibuf_cnt);
  assign credit_ok = (occupancy < SUM_W'(FIFO_DEPTH)) && !tag_full;

  // rst_n gating drops the request as soon as reset asserts, before any edge.
  assign imem_req   = rst_n && !jump && credit_ok;
  assign imem_addr  = pc;
  assign accept     = imem_req && imem_gnt;
  assign pc_stall_n = accept;

  // Response is kept only when no stale requests precede it and no jump is
  // flushing this cycle.
  assign resp_keep = imem_rvalid && !jump && (drop_cnt_q == '0);

  // PC tags for requests in flight; its occupancy is the in-flight count.
  if_sync_fifo #(
    .T     (logic [PC_W-1:0]),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (pc),
    .pop_i   (imem_rvalid),
    .flush_i (1'b0),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  assign ibuf_din.pc    = tag_head;
  assign ibuf_din.instr = imem_rdata;

  // Decode-side handshake, with or without the zero-latency pass-through.
`ifdef IF_FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = resp_keep && ibuf_empty;
  assign id_valid  = (!ibuf_empty && !jump) || bypass;
  assign id_instr  = bypass ? imem_rdata : ibuf_head.instr;
  assign id_pc     = bypass ? tag_head   : ibuf_head.pc;
  assign ibuf_push = resp_keep && !(bypass && id_ready);
  assign ibuf_pop  = !ibuf_empty && !jump && id_ready;
`else
  assign id_valid  = !ibuf_empty && !jump;
  assign id_instr  = ibuf_head.instr;
  assign id_pc     = ibuf_head.pc;
  assign ibuf_push = resp_keep;
  assign ibuf_pop  = id_valid && id_ready;
`endif

  // Instruction buffer toward decode; a jump empties it.
  if_sync_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ibuf_push),
    .data_i  (ibuf_din),
    .pop_i   (ibuf_pop),
    .flush_i (jump),
    .data_o  (ibuf_head),
    .full_o  (ibuf_full),
    .empty_o (ibuf_empty),
    .count_o (ibuf_cnt)
  );

  // Stale-response counter. No request is accepted in a jump cycle, so the
  // in-flight count after this cycle is tag_cnt minus any response now.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (jump) begin
      drop_cnt_d = tag_cnt - CNT_W'(imem_rvalid);
    end else if (imem_rvalid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  // The credit rule must keep a kept response from ever meeting a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(ibuf_push && ibuf_full && !ibuf_pop));

  // Memory may only respond to a request it has been granted.
  assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> !tag_empty);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import if_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic        jump = 1'b0;
  logic        pc_stall_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .FIFO_DEPTH (DEPTH),
    .PC_W       (32),
    .INSTR_W    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .jump        (jump),
    .pc_stall_n  (pc_stall_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  typedef struct {
    logic [31:0] pc;
    int unsigned rdy;
    bit          stale;
  } req_t;

  req_t         out_q [$];   // memory model: requests granted, awaiting response
  fetch_entry_t exp_q [$];   // scoreboard: entries expected at decode, in order
  logic [31:0]  deliv_q [$]; // log of PCs handed to decode

  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned acc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        gnt_ctl = 1'b0;
  logic        ready_ctl = 1'b0;
  logic        jump_ctl = 1'b0;
  logic [31:0] pc_nxt = '0;
  logic [31:0] target = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, check and update the model at negedge.
  task automatic step();
    req_t         r;
    fetch_entry_t e, e_resp;
    bit           resp, keep, byp, exp_req, exp_vld;
    @(posedge clk);
    cyc++;
    #1;
    pc       = pc_nxt;
    jump     = jump_ctl;
    imem_gnt = gnt_ctl;
    id_ready = ready_ctl;
    resp = (out_q.size() != 0) && (out_q[0].rdy <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? (out_q[0].pc ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    @(negedge clk);

    exp_req = !jump && ((out_q.size() + exp_q.size()) < int'(DEPTH));
    check_eq("imem_req", 64'(imem_req), 64'(exp_req));
    check_eq("pc_stall_n", 64'(pc_stall_n), 64'(exp_req && imem_gnt));
    if (imem_req) check_eq("imem_addr", 64'(imem_addr), 64'(pc));

    keep   = 1'b0;
    e_resp = '0;
    if (resp) begin
      r = out_q.pop_front();
      keep = !r.stale && !jump;
      e_resp.pc    = r.pc;
      e_resp.instr = r.pc ^ 32'hA5A5_0000;
    end
    byp = 1'b0;
`ifdef IF_FETCH_BYPASS_EN
    byp = keep && (exp_q.size() == 0);
`endif
    exp_vld = ((exp_q.size() != 0) && !jump) || byp;
    check_eq("id_valid", 64'(id_valid), 64'(exp_vld));
    if (exp_vld && id_ready) begin
      if (byp) e = e_resp;
      else     e = exp_q.pop_front();
      check_eq("id_pc", 64'(id_pc), 64'(e.pc));
      check_eq("id_instr", 64'(id_instr), 64'(e.instr));
      deliv_q.push_back(e.pc);
    end
    if (keep && !(byp && id_ready)) exp_q.push_back(e_resp);

    if (jump) begin
      exp_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
    end
    if (imem_req && imem_gnt) begin
      r.pc    = imem_addr;
      r.rdy   = cyc + lat;
      r.stale = 1'b0;
      out_q.push_back(r);
      acc_cnt++;
    end
    if (jump)                       pc_nxt = target;
    else if (imem_req && imem_gnt)  pc_nxt = pc + 32'd4;
  endtask

  // Assert reset between edges, check the immediate output response, restart at start_pc.
  task automatic do_reset(input logic [31:0] start_pc);
    #2;
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    jump        = 1'b0;
    jump_ctl    = 1'b0;
    #1;
    check_eq("rst_imem_req", 64'(imem_req), 64'd0);
    check_eq("rst_id_valid", 64'(id_valid), 64'd0);
    check_eq("rst_pc_stall_n", 64'(pc_stall_n), 64'd0);
    check_eq("rst_id_instr", 64'(id_instr), 64'd0);
    check_eq("rst_id_pc", 64'(id_pc), 64'd0);
    out_q.delete();
    exp_q.delete();
    pc     = start_pc;
    pc_nxt = start_pc;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Stop issuing and let everything outstanding reach decode.
  task automatic drain();
    gnt_ctl   = 1'b0;
    ready_ctl = 1'b1;
    jump_ctl  = 1'b0;
    for (int i = 0; i < 40 && (out_q.size() + exp_q.size()) != 0; i++) step();
    check_eq("drain_empty", 64'(out_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mark;
    int unsigned acc0;
    logic [31:0] got_pc;

    // Streaming from pc=0
    do_reset(32'h0);
    lat = 1; gnt_ctl = 1'b1; ready_ctl = 1'b1;
    mark = deliv_q.size();
    for (int i = 0; i < 24; i++) step();
    drain();
    check_eq("stream_count_ge12", 64'((deliv_q.size() - mark) >= 12), 64'd1);
    for (int i = 0; i < 12; i++) begin
      got_pc = (deliv_q.size() > mark + i) ? deliv_q[mark + i] : 32'hFFFF_FFFF;
      check_eq("stream_order", 64'(got_pc), 64'(32'(4 * i)));
    end

    // Back-pressure: decode stalled, exactly DEPTH requests go out
    do_reset(32'h0);
    lat = 1; gnt_ctl = 1'b1; ready_ctl = 1'b0;
    acc0 = acc_cnt;
    mark = deliv_q.size();
    for (int i = 0; i < 6; i++) step();
    check_eq("bp_accepts", 64'(acc_cnt - acc0), 64'(DEPTH));
    check_eq("bp_req_low", 64'(imem_req), 64'd0);
    ready_ctl = 1'b1;
    for (int i = 0; i < 6; i++) step();
    drain();
    for (int i = 0; i < 3; i++) begin
      got_pc = (deliv_q.size() > mark + i) ? deliv_q[mark + i] : 32'hFFFF_FFFF;
      check_eq("bp_order", 64'(got_pc), 64'(32'(4 * i)));
    end

    // Jump with two requests in flight and no response in the jump cycle
    do_reset(32'h0);
    lat = 4; gnt_ctl = 1'b1; ready_ctl = 1'b1;
    for (int i = 0; i < 10 && out_q.size() != 2; i++) step();
    check_eq("j1_inflight", 64'(out_q.size()), 64'd2);
    mark = deliv_q.size();
    target = 32'h200; jump_ctl = 1'b1;
    step();
    jump_ctl = 1'b0; lat = 1;
    step();
    check_eq("j1_drop_cnt", 64'(dut.drop_cnt_q), 64'd2);
    for (int i = 0; i < 8; i++) step();
    drain();
    got_pc = (deliv_q.size() > mark) ? deliv_q[mark] : 32'hFFFF_FFFF;
    check_eq("j1_first_pc", 64'(got_pc), 64'h200);

    // Jump coincident with a response, one more outstanding
    do_reset(32'h0);
    lat = 2; gnt_ctl = 1'b1; ready_ctl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_q.size() == 2 && out_q[0].rdy == cyc + 1) break;
      step();
    end
    check_eq("j2_setup", 64'(out_q.size() == 2 && out_q[0].rdy == cyc + 1), 64'd1);
    mark = deliv_q.size();
    target = 32'h300; jump_ctl = 1'b1;
    step();
    jump_ctl = 1'b0;
    step();
    check_eq("j2_drop_after_jump", 64'(dut.drop_cnt_q), 64'd1);
    for (int i = 0; i < 6; i++) step();
    drain();
    check_eq("j2_drop_final", 64'(dut.drop_cnt_q), 64'd0);
    got_pc = (deliv_q.size() > mark) ? deliv_q[mark] : 32'hFFFF_FFFF;
    check_eq("j2_first_pc", 64'(got_pc), 64'h300);

    // Grant withheld: request and address held, PC frozen
    do_reset(32'h40);
    lat = 1; gnt_ctl = 1'b0; ready_ctl = 1'b1;
    mark = deliv_q.size();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("gnt_stall_addr", 64'(imem_addr), 64'h40);
    end
    gnt_ctl = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drain();
    got_pc = (deliv_q.size() > mark) ? deliv_q[mark] : 32'hFFFF_FFFF;
    check_eq("gnt_stall_first_pc", 64'(got_pc), 64'h40);

    // Asynchronous reset in the middle of streaming
    lat = 1; gnt_ctl = 1'b1; ready_ctl = 1'b1;
    for (int i = 0; i < 5; i++) step();
    do_reset(32'h100);
    acc0 = acc_cnt;
    step();
    check_eq("post_rst_acc", 64'(acc_cnt - acc0), 64'd1);
    got_pc = (out_q.size() > 0) ? out_q[0].pc : 32'hFFFF_FFFF;
    check_eq("post_rst_addr", 64'(got_pc), 64'h100);
    for (int i = 0; i < 4; i++) step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
